// File: rtl/fifo_burst_reader.sv
// Read-side burst master for the 8-deep synchronous FIFO: drains a programmed number of words
// and forwards each one over a valid/ready handshake while accumulating a checksum.
module fifo_burst_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  burst_len,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_d_out,
  input  logic                  fifo_rd_ack,
  input  logic                  fifo_rd_err,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum,
  output logic [CNT_WIDTH-1:0]  words_read,
  output logic [CNT_WIDTH-1:0]  err_count
);

  localparam int unsigned MaxBurst = 8;
  localparam logic [CNT_WIDTH-1:0] MaxBurstCnt = CNT_WIDTH'(MaxBurst);
  localparam logic [CNT_WIDTH-1:0] ErrSat      = '1;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWait,
    StSend,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
  logic [CNT_WIDTH-1:0]  words_read_q, words_read_d;
  logic [CNT_WIDTH-1:0]  err_count_q, err_count_d;
  logic [CNT_WIDTH-1:0]  len_clamped;

  // Requests beyond the FIFO depth can never complete, so cap them at a full drain.
  always_comb begin
    len_clamped = burst_len;
    if (burst_len > MaxBurstCnt) begin
      len_clamped = MaxBurstCnt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      remaining_q  <= '0;
      out_data_q   <= '0;
      checksum_q   <= '0;
      words_read_q <= '0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      out_data_q   <= out_data_d;
      checksum_q   <= checksum_d;
      words_read_q <= words_read_d;
      err_count_q  <= err_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    out_data_d   = out_data_q;
    checksum_d   = checksum_q;
    words_read_d = words_read_q;
    err_count_d  = err_count_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          remaining_d  = len_clamped;
          checksum_d   = '0;
          words_read_d = '0;
          err_count_d  = '0;
          state_d      = (burst_len == '0) ? StDone : StRead;
        end
      end

      StRead: begin
        if (!fifo_empty) begin
          state_d = StWait;
        end
      end

      StWait: begin
        // Ack wins if both flags are seen; anything short of an ack means re-issue the read.
        if (fifo_rd_ack) begin
          out_data_d   = fifo_d_out;
          checksum_d   = checksum_q + fifo_d_out;
          words_read_d = words_read_q + 1'b1;
          remaining_d  = remaining_q - 1'b1;
          state_d      = StSend;
        end else begin
          if (fifo_rd_err && (err_count_q != ErrSat)) begin
            err_count_d = err_count_q + 1'b1;
          end
          state_d = StRead;
        end
      end

      StSend: begin
        if (out_ready) begin
          state_d = (remaining_q == '0) ? StDone : StRead;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Handshake outputs decode straight from state so reset clears them without a clock.
  always_comb begin
    fifo_rd_en = (state_q == StRead) && !fifo_empty;
    out_valid  = (state_q == StSend);
    busy       = (state_q != StIdle);
    done       = (state_q == StDone);
  end

  assign out_data   = out_data_q;
  assign checksum   = checksum_q;
  assign words_read = words_read_q;
  assign err_count  = err_count_q;

  a_rd_en_legal: assert property (@(posedge clk) disable iff (!reset_n)
      fifo_rd_en |-> (state_q == StRead) && !fifo_empty);

  a_send_hold: assert property (@(posedge clk) disable iff (!reset_n)
      (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

  a_done_pulse: assert property (@(posedge clk) disable iff (!reset_n)
      done |=> !done);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomized bench for fifo_burst_reader: a queue-based FIFO model feeds the DUT and a
// queue/arithmetic reference predicts forwarded words, checksum and counters per burst.
module tb_fifo_burst_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [CW-1:0] burst_len;
  logic          fifo_empty;
  logic [DW-1:0] fifo_d_out = '0;
  logic          fifo_rd_ack = 1'b0;
  logic          fifo_rd_err = 1'b0;
  logic          fifo_rd_en;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;
  logic [CW-1:0] words_read;
  logic [CW-1:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_burst_reader #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .burst_len  (burst_len),
    .fifo_empty (fifo_empty),
    .fifo_d_out (fifo_d_out),
    .fifo_rd_ack(fifo_rd_ack),
    .fifo_rd_err(fifo_rd_err),
    .fifo_rd_en (fifo_rd_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum),
    .words_read (words_read),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // FIFO model: registered response on the edge that samples rd_en; injected errors refuse a
  // read without consuming a word.
  logic [DW-1:0] fifo_q[$];
  int            fifo_cnt    = 0;
  int            inject_req  = 0;
  int            inject_done = 0;

  assign fifo_empty = (fifo_cnt == 0);

  always @(posedge clk) begin
    fifo_rd_ack <= 1'b0;
    fifo_rd_err <= 1'b0;
    if (fifo_rd_en) begin
      if ((inject_req > inject_done) || (fifo_q.size() == 0)) begin
        fifo_rd_err <= 1'b1;
        if (inject_req > inject_done) inject_done <= inject_done + 1;
      end else begin
        fifo_d_out  <= fifo_q.pop_front();
        fifo_rd_ack <= 1'b1;
      end
    end
    fifo_cnt <= fifo_q.size();
  end

  // Monitor
  int            rd_cnt   = 0;
  int            done_cnt = 0;
  logic [DW-1:0] obs_q[$];

  always @(posedge clk) begin
    if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (out_valid && out_ready) obs_q.push_back(out_data);
  end

  // Downstream: 0 always ready, 1 random, 2 four stall cycles per word, 3 never ready
  int            ready_mode = 0;
  int            stall_ctr  = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  always @(negedge clk) begin
    if (prev_stall && reset_n) begin
      check_eq("hold_valid", DW'(out_valid), 32'd1);
      check_eq("hold_data", out_data, prev_data);
    end
    if (fifo_rd_en) check_eq("rd_en_while_empty", DW'(fifo_empty), 32'd0);
    case (ready_mode)
      1: out_ready = 1'($urandom_range(0, 1));
      2: begin
        if (!out_valid) begin
          stall_ctr = 0;
          out_ready = 1'b1;
        end else if (stall_ctr < 4) begin
          stall_ctr++;
          out_ready = 1'b0;
        end else begin
          out_ready = 1'b1;
        end
      end
      3: out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
    prev_stall = out_valid && !out_ready && reset_n;
    prev_data  = out_data;
  end

  logic [DW-1:0] stim[8];

  task automatic pulse_start(input logic [CW-1:0] len);
    start     = 1'b1;
    burst_len = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input string tag);
    int cyc = 0;
    while ((done_cnt <= base) && (cyc < 400)) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_done_seen"}, DW'(done_cnt > base), 32'd1);
  endtask

  // One burst end to end. late: start on an empty FIFO and trickle the words in.
  // poke: issue a second start mid-burst, which must be ignored.
  task automatic run_burst(input string tag, input int n_push, input int len, input int n_inj,
                           input bit late, input bit poke);
    int            n_exp;
    int            rd0;
    int            dn0;
    logic [DW-1:0] sum;
    n_exp = (len > 8) ? 8 : len;
    sum   = '0;
    for (int i = 0; i < n_exp; i++) sum = sum + stim[i];
    obs_q.delete();
    inject_req = inject_req + n_inj;
    if (!late) for (int i = 0; i < n_push; i++) fifo_q.push_back(stim[i]);
    @(negedge clk);
    rd0 = rd_cnt;
    dn0 = done_cnt;
    pulse_start(CW'(len));
    if (late) begin
      repeat (10) @(negedge clk);
      check_eq({tag, "_stall_busy"}, DW'(busy), 32'd1);
      check_eq({tag, "_stall_rd_en"}, DW'(fifo_rd_en), 32'd0);
      check_eq({tag, "_stall_reads"}, DW'(rd_cnt - rd0), 32'd0);
      for (int i = 0; i < n_push; i++) begin
        fifo_q.push_back(stim[i]);
        repeat (4) @(negedge clk);
      end
    end
    if (poke) begin
      repeat (4) @(negedge clk);
      pulse_start(CW'(3));
    end
    wait_done(dn0, tag);
    @(negedge clk);
    check_eq({tag, "_nwords"}, DW'(obs_q.size()), DW'(n_exp));
    for (int i = 0; i < n_exp; i++) begin
      if (i < obs_q.size()) check_eq({tag, "_word"}, obs_q[i], stim[i]);
    end
    check_eq({tag, "_checksum"}, checksum, sum);
    check_eq({tag, "_words_read"}, DW'(words_read), DW'(n_exp));
    check_eq({tag, "_err_count"}, DW'(err_count), DW'(n_inj));
    check_eq({tag, "_rd_pulses"}, DW'(rd_cnt - rd0), DW'(n_exp + n_inj));
    check_eq({tag, "_done_pulses"}, DW'(done_cnt - dn0), 32'd1);
    check_eq({tag, "_fifo_left"}, DW'(fifo_q.size()), DW'(n_push - n_exp));
    check_eq({tag, "_busy_end"}, DW'(busy), 32'd0);
    fifo_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int n_exp;
    reset_n   = 1'b0;
    start     = 1'b0;
    burst_len = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_out_data", out_data, 32'd0);
    check_eq("rst_out_valid", DW'(out_valid), 32'd0);
    check_eq("rst_busy", DW'(busy), 32'd0);
    check_eq("rst_done", DW'(done), 32'd0);
    check_eq("rst_checksum", checksum, 32'd0);
    check_eq("rst_words_read", DW'(words_read), 32'd0);
    check_eq("rst_err_count", DW'(err_count), 32'd0);
    check_eq("rst_rd_en", DW'(fifo_rd_en), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    stim[0] = 32'h0230_0000;
    stim[1] = 32'h1234_0000;
    stim[2] = 32'h5234_2345;
    ready_mode = 0;
    run_burst("basic3", 3, 3, 0, 1'b0, 1'b0);
    check_eq("basic3_sum_const", checksum, 32'h6698_2345);

    ready_mode = 2;
    run_burst("stall3", 3, 3, 0, 1'b0, 1'b0);

    // Reset while a word is being offered downstream
    ready_mode = 3;
    for (int i = 0; i < 3; i++) fifo_q.push_back(stim[i]);
    @(negedge clk);
    pulse_start(CW'(3));
    for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
    check_eq("midrst_valid_before", DW'(out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", DW'(out_valid), 32'd0);
    check_eq("midrst_busy", DW'(busy), 32'd0);
    check_eq("midrst_out_data", out_data, 32'd0);
    check_eq("midrst_checksum", checksum, 32'd0);
    check_eq("midrst_words_read", DW'(words_read), 32'd0);
    check_eq("midrst_rd_en", DW'(fifo_rd_en), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    len     = rd_cnt;
    repeat (3) @(negedge clk);
    check_eq("midrst_no_read", DW'(rd_cnt - len), 32'd0);
    check_eq("midrst_fifo_left", DW'(fifo_q.size()), 32'd2);
    check_eq("midrst_idle", DW'(busy), 32'd0);
    fifo_q.delete();
    ready_mode = 0;
    @(negedge clk);

    stim[0] = 32'hAAAA_EEEE;
    stim[1] = 32'hCCCC_CCCC;
    run_burst("late2", 2, 2, 0, 1'b1, 1'b0);
    check_eq("late2_sum_const", checksum, 32'h7777_BBBA);

    ready_mode = 1;
    for (int i = 0; i < 8; i++) stim[i] = $urandom;
    run_burst("full8", 8, 8, 0, 1'b0, 1'b1);
    run_burst("zero_len", 0, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) stim[i] = $urandom;
    run_burst("rd_err", 4, 4, 1, 1'b0, 1'b0);

    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 8; i++) stim[i] = $urandom;
      len        = $urandom_range(1, 12);
      n_exp      = (len > 8) ? 8 : len;
      ready_mode = $urandom_range(0, 2);
      run_burst("rand", $urandom_range(n_exp, 8), len, $urandom_range(0, 2), 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
